// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control blocks: register address
// width, operand-mux forward select codes and the in-flight destination tag.
package cpu_pkg;

  localparam int REG_AW = 4;

  localparam logic [1:0] FWD_EXMEM = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_WB1   = 2'b10;
  localparam logic [1:0] FWD_NONE  = 2'b11;

  // valid is only set for real instructions that write rd, so a tag match
  // never needs the producer's write enable separately.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } tag_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority: the nearest in-flight producer of the
// source register wins; r0 and unused sources never forward.
module fwd_select
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  tag_t              t_ex,
  input  tag_t              t_mem,
  input  tag_t              t_wb,
  output logic [1:0]        sel
);

  logic src_live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign src_live = used && (src != '0);
  assign hit_ex   = src_live && t_ex.valid  && (t_ex.rd  == src);
  assign hit_mem  = src_live && t_mem.valid && (t_mem.rd == src);
  assign hit_wb   = src_live && t_wb.valid  && (t_wb.rd  == src);

  always_comb begin
    sel = FWD_NONE;
    if (hit_ex)       sel = FWD_EXMEM;
    else if (hit_mem) sel = FWD_MEMWB;
    else if (hit_wb)  sel = FWD_WB1;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-to-execute hazard controller: tracks destination tags in flight,
// registers operand forward selects for EX and stalls once on load-use.
module hazard_forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              ex_flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_bubble
);

  tag_t       t_ex;
  tag_t       t_mem;
  tag_t       t_wb;
  tag_t       t_new;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       hazard;
  logic       issue;

  fwd_select u_sel_a (
    .src   (id_rs),
    .used  (id_rs_used),
    .t_ex  (t_ex),
    .t_mem (t_mem),
    .t_wb  (t_wb),
    .sel   (sel_a)
  );

  fwd_select u_sel_b (
    .src   (id_rt),
    .used  (id_rt_used),
    .t_ex  (t_ex),
    .t_mem (t_mem),
    .t_wb  (t_wb),
    .sel   (sel_b)
  );

  // A load one slot ahead has no data until MEM/WB; after the single bubble
  // it sits in T_MEM, so the same decode instruction cannot stall again.
  assign hazard = id_valid && t_ex.is_load &&
                  ((sel_a == FWD_EXMEM) || (sel_b == FWD_EXMEM));
  assign stall  = hazard && !ex_flush;
  assign issue  = id_valid && !ex_flush && !hazard;

  always_comb begin
    t_new         = '0;
    t_new.valid   = issue && id_wr_en;
    t_new.rd      = id_rd;
    t_new.is_load = issue && id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_ex      <= '0;
      t_mem     <= '0;
      t_wb      <= '0;
      fwd_a_sel <= FWD_NONE;
      fwd_b_sel <= FWD_NONE;
      ex_bubble <= 1'b1;
    end else begin
      t_wb      <= t_mem;
      t_mem     <= t_ex;
      t_ex      <= t_new;
      fwd_a_sel <= issue ? sel_a : FWD_NONE;
      fwd_b_sel <= issue ? sel_b : FWD_NONE;
      ex_bubble <= !issue;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed pipeline scenarios then
// random instruction streams against a history-based reference model.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_rs = '0;
  logic [3:0] id_rt = '0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic [3:0] id_rd = '0;
  logic       id_wr_en = 1'b0;
  logic       id_is_load = 1'b0;
  logic       ex_flush = 1'b0;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       ex_bubble;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit wr;
    int rd;
    bit ld;
  } ent_t;

  typedef struct {
    int a;
    int b;
    bit bub;
    string tag;
  } exp_t;

  ent_t hist[$];   // instructions that entered EX, newest first
  exp_t expq[$];

  hazard_forward_unit dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .ex_flush   (ex_flush),
    .stall      (stall),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .ex_bubble  (ex_bubble)
  );

  always #5 clk = ~clk;

  // Distance of the nearest earlier producer of s (1..3), 0 if none.
  function automatic int producer_dist(int s, bit used);
    if (!used || s == 0) return 0;
    for (int k = 0; k < hist.size() && k < 3; k++)
      if (hist[k].wr && hist[k].rd == s) return k + 1;
    return 0;
  endfunction

  function automatic int dist_to_sel(int d);
    case (d)
      1: return 0;
      2: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic step(input string tag, input bit v, input int rs, input bit rsu,
                      input int rt, input bit rtu, input int rd, input bit we,
                      input bit ld, input bit fl, output bit exp_stall);
    int da, db;
    bit hz, acc;
    exp_t e;
    ent_t n;
    @(negedge clk);
    rst = 1'b0;
    id_valid = v; id_rs = rs[3:0]; id_rs_used = rsu; id_rt = rt[3:0];
    id_rt_used = rtu; id_rd = rd[3:0]; id_wr_en = we; id_is_load = ld;
    ex_flush = fl;
    #1;
    da = producer_dist(rs, rsu);
    db = producer_dist(rt, rtu);
    hz = v && (da == 1 || db == 1) && hist.size() > 0 && hist[0].ld;
    exp_stall = hz && !fl;
    acc = v && !fl && !hz;
    checks++;
    if (stall !== exp_stall) begin
      errors++;
      $display("FAIL %s stall: got %0b want %0b", tag, stall, exp_stall);
    end
    e.a = acc ? dist_to_sel(da) : 3;
    e.b = acc ? dist_to_sel(db) : 3;
    e.bub = !acc;
    e.tag = tag;
    expq.push_back(e);
    n.wr = acc && we; n.rd = rd; n.ld = acc && ld;
    hist.push_front(n);
    if (hist.size() > 3) void'(hist.pop_back());
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; id_valid = 1'b0; ex_flush = 1'b0;
    e.a = 3; e.b = 3; e.bub = 1'b1; e.tag = tag;
    expq.push_back(e);
    hist.delete();
  endtask

  // Monitor: outputs are registered, so every cycle presents one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (fwd_a_sel !== e.a[1:0] || fwd_b_sel !== e.b[1:0] || ex_bubble !== e.bub) begin
          errors++;
          $display("FAIL %s ex: got a=%0d b=%0d bub=%0b want a=%0d b=%0d bub=%0b",
                   e.tag, fwd_a_sel, fwd_b_sel, ex_bubble, e.a, e.b, e.bub);
        end
      end
    end
  end

  initial begin
    bit s;
    bit held;
    int v, rs, rsu, rt, rtu, rd, we, ld, fl;
    repeat (2) @(posedge clk);
    do_reset("reset");

    step("add_r3",   1, 1, 1, 2, 1, 3, 1, 0, 0, s);
    step("sub_r3",   1, 3, 1, 1, 1, 4, 1, 0, 0, s);

    step("w_r5",     1, 1, 1, 2, 1, 5, 1, 0, 0, s);
    step("indep",    1, 1, 1, 2, 1, 7, 1, 0, 0, s);
    step("dist2",    1, 5, 1, 1, 1, 8, 1, 0, 0, s);
    step("w_r5b",    1, 1, 1, 2, 1, 5, 1, 0, 0, s);
    step("indep",    1, 1, 1, 2, 1, 7, 1, 0, 0, s);
    step("indep",    1, 2, 1, 1, 1, 7, 1, 0, 0, s);
    step("dist3",    1, 1, 1, 5, 1, 9, 1, 0, 0, s);

    step("lw_r2",    1, 1, 1, 0, 0, 2, 1, 1, 0, s);
    step("lu_stall", 1, 2, 1, 2, 1, 6, 1, 0, 0, s);
    step("lu_retry", 1, 2, 1, 2, 1, 6, 1, 0, 0, s);

    step("w_r0",     1, 1, 1, 2, 1, 0, 1, 0, 0, s);
    step("rd_r0",    1, 0, 1, 0, 1, 6, 1, 0, 0, s);
    step("w_r8",     1, 1, 1, 2, 1, 8, 1, 0, 0, s);
    step("rt_unused",1, 1, 1, 8, 0, 6, 1, 0, 0, s);

    step("lw_r9",    1, 1, 1, 0, 0, 9, 1, 1, 0, s);
    step("lu_flush", 1, 9, 1, 1, 1, 6, 1, 0, 1, s);
    step("after_fl", 1, 1, 1, 2, 1, 6, 1, 0, 0, s);

    step("w_r10",    1, 1, 1, 2, 1, 10, 1, 0, 0, s);
    do_reset("mid_reset");
    step("rd_r10",   1, 10, 1, 10, 1, 6, 1, 0, 0, s);

    held = 1'b0;
    v = 0; rs = 0; rsu = 0; rt = 0; rtu = 0; rd = 0; we = 0; ld = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rand_reset");
        held = 1'b0;
      end else begin
        if (!held) begin
          v   = ($urandom_range(0, 7) != 0);
          rs  = $urandom_range(0, 7);
          rt  = $urandom_range(0, 7);
          rsu = ($urandom_range(0, 4) != 0);
          rtu = ($urandom_range(0, 4) != 0);
          rd  = $urandom_range(0, 7);
          we  = ($urandom_range(0, 5) != 0);
          ld  = ($urandom_range(0, 2) == 0) && we;
        end
        fl = ($urandom_range(0, 9) == 0);
        step("rand", v[0], rs, rsu[0], rt, rtu[0], rd, we[0], ld[0], fl[0], s);
        held = s;
      end
    end

    @(negedge clk);
    id_valid = 1'b0; ex_flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard and operand-forwarding controller for the 16-bit 5-stage CPU. It sits between decode and execute. It tracks the destination tags of instructions in flight and computes forwarding selects at decode. The selects are registered so they are valid for the whole EX cycle, where they drive the `selectBottom` input of each ALU operand 5:1 mux. The block also detects load-use hazards, raises a one-cycle stall, and injects a bubble into EX.

## Interface
Parameters:
- `REG_AW`, default 4: register-address width (16 architectural registers; r0 reads as zero).

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `id_valid` input 1: the decode-stage instruction is real (not a bubble).
- `id_rs`, `id_rt` input REG_AW: source register addresses of the decode-stage instruction.
- `id_rs_used`, `id_rt_used` input 1: the corresponding source is actually read.
- `id_rd` input REG_AW: destination register of the decode-stage instruction.
- `id_wr_en` input 1: the decode-stage instruction writes `id_rd`.
- `id_is_load` input 1: the decode-stage instruction is a load.
- `ex_flush` input 1: taken branch or jump resolved in EX; kill the instruction leaving decode.
- `stall` output 1: combinational; freezes PC and the IF/ID register this cycle.
- `fwd_a_sel`, `fwd_b_sel` output 2: registered; operand A/B `selectBottom` codes, valid during EX.
- `ex_bubble` output 1: registered; the instruction now in EX is a bubble.

## Operation
- Select encoding (fixed by the operand mux):
  - 2'b00: forward the EX/MEM ALU result.
  - 2'b01: forward the MEM/WB result (ALU or load data).
  - 2'b10: forward the WB+1 shadow write data, which covers the register file's lack of write-through.
  - 2'b11: no forward (register file or immediate, chosen by `selectTop`).
- Internal tag pipeline: three stages, T_EX, T_MEM and T_WB. Each holds {valid, rd, is_load}. All three shift every cycle; the CPU has no memory stalls.
- A tag *matches* source s when all of the following hold:
  - the tag is valid;
  - the instruction's write enable was set;
  - tag rd equals s;
  - s is not 0;
  - the source is marked used.
- Forward select per operand, nearest producer first:
  - T_EX matches: 00.
  - Otherwise T_MEM matches: 01.
  - Otherwise T_WB matches: 10.
  - Otherwise: 11.
- Load-use hazard: T_EX matches a used source, T_EX.is_load is 1, and `id_valid` is 1. The response is:
  - `stall` is 1.
  - A bubble (valid=0) is shifted into T_EX.
  - `fwd_*_sel` are registered as 11.
  - `ex_bubble` is registered as 1.
  - Next cycle the same decode instruction is re-evaluated; the load is now in T_MEM, so the select becomes 01.
- `ex_flush` takes priority over a hazard:
  - `stall` is 0.
  - A bubble enters T_EX.
  - The selects are registered as 11 and `ex_bubble` as 1.
- If `id_valid` is 0, a bubble enters T_EX, the selects are 11, and `stall` is 0.
- Only one load-use stall occurs per hazard; the design never stalls two consecutive cycles for the same producer.

## Timing
- Reset (synchronous, `rst` high at a rising edge):
  - all tags become invalid;
  - `fwd_a_sel` and `fwd_b_sel` become 2'b11;
  - `ex_bubble` becomes 1;
  - `stall` is 0 while tags are invalid.
- Reset mid-operation discards every in-flight tag. The first instruction after reset never forwards.
- Select latency: one cycle. The decode-cycle evaluation appears on `fwd_*_sel` in the following (EX) cycle and holds for exactly that cycle.
- `stall` is combinational from the `id_*` inputs and T_EX, in the same cycle.
- Write-after-write: when several tags match the same source, the youngest (nearest) wins.
- An instruction that both reads and writes one register uses the older producer's value. Its own tag does not match itself.

## Structure
- Shared package `cpu_pkg`:
  - `REG_AW`;
  - the forward-select constants `FWD_EXMEM`=2'b00, `FWD_MEMWB`=2'b01, `FWD_WB1`=2'b10, `FWD_NONE`=2'b11;
  - a tag struct {valid, rd, is_load}.
- One sub-module is natural: `fwd_select`, the combinational per-operand priority match, instantiated twice (rs and rt).
- Tag shift registers and the hazard logic live in the top level.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: `add r3,..` then `sub r4,r3,r1`.
  - Required: `fwd_a_sel`=00 in the sub's EX cycle, `fwd_b_sel`=11, no stall.
- Two-apart and three-apart dependencies:
  - Stimulus: a write to r5, then one or two independent instructions, then a reader of r5.
  - Required: the select is 01 at distance 2 and 10 at distance 3.
- Load-use:
  - Stimulus: `lw r2` immediately followed by `add r6,r2,r2`.
  - Required: `stall`=1 for exactly one cycle and `ex_bubble`=1 for that EX slot, then `fwd_a_sel`=`fwd_b_sel`=01.
- r0 and unused sources:
  - Stimulus: a producer of r0; separately, a matching rt with `id_rt_used`=0.
  - Required: the select stays 11.
- Flush during hazard:
  - Stimulus: the load-use condition with `ex_flush`=1 in the same cycle.
  - Required: `stall`=0, `ex_bubble`=1, selects 11 next cycle.
- Reset mid-stream:
  - Stimulus: assert `rst` for one cycle between a producer and its consumer.
  - Required: the consumer's select is 11, and `ex_bubble`=1 right after reset.
